// File: rtl/am_lock_multimode_if.sv
// Coded-block stream bundle shared by the AM lock input and output sides.
// master drives valid/data, slave consumes them.
interface am_lock_multimode_if #(
  parameter int NB_CODED_BLOCK = 66
);
  logic                      valid;
  logic [NB_CODED_BLOCK-1:0] data;

  modport master (output valid, output data);
  modport slave  (input  valid, input  data);
endinterface

// File: rtl/am_lock_multimode.sv
// Per-lane alignment-marker lock for the RX PCS: candidate search,
// lock FSM with lane pinning, AM removal and BIP error counting.
module am_lock_multimode #(
  parameter int NB_CODED_BLOCK    = 66,
  parameter int N_ALIGNER         = 20,
  parameter int NB_LANE_ID        = $clog2(N_ALIGNER),
  parameter int NB_AM             = 48,
  parameter logic [N_ALIGNER*NB_AM-1:0] AM_TABLE = {
    48'hC0F0E53F0F1A, 48'h5F662AA099D5, 48'hADD6B7522948,
    48'hC4314C3BCEB3, 48'h3536CDCAC932, 48'h83C7CA7C3835,
    48'h1AF8BDE50742, 48'h5CB9B2A3464D, 48'hB99155466EAA,
    48'hFD6C99029366, 48'h68C9FB973604, 48'hA024765FDB89,
    48'h7B456684BA99, 48'h9A4A2665B5D9, 48'hDD14C222EB3D,
    48'hF507090AF8F6, 48'h4D957BB26A84, 48'h594BE8A6B417,
    48'h9D718E628E71, 48'hC168213E97DE},
  parameter int NB_AM_PERIOD      = 16,
  parameter int NB_VAL_AM         = 5,
  parameter int NB_INV_AM         = 3,
  parameter int NB_ERROR_COUNTER  = 32,
  parameter int NB_RESYNC_COUNTER = 8
) (
  input  logic                         i_clock,
  input  logic                         i_reset,
  input  logic                         i_rf_enable,
  input  logic                         i_block_lock,
  input  logic [7:0]                   i_calculated_bip,
  input  logic [NB_AM-1:0]             i_rf_compare_mask,
  input  logic [NB_LANE_ID:0]          i_rf_n_active,
  input  logic [NB_VAL_AM-1:0]         i_rf_valid_am_thr,
  input  logic [NB_INV_AM-1:0]         i_rf_invalid_am_thr,
  input  logic [NB_AM_PERIOD-1:0]      i_rf_am_period,
  am_lock_multimode_if.slave           rx,
  am_lock_multimode_if.master          tx,
  output logic                         o_start_of_lane,
  output logic [NB_LANE_ID-1:0]        o_lane_id,
  output logic                         o_am_lock,
  output logic                         o_resync,
  output logic                         o_bip_restart,
  output logic [NB_ERROR_COUNTER-1:0]  o_error_counter,
  output logic [NB_RESYNC_COUNTER-1:0] o_resync_counter
);

  localparam logic [NB_CODED_BLOCK-1:0] AM_IDLE = {2'b10, 8'h1E, 56'h0};

  typedef enum logic [1:0] {SEARCH, CONFIRM, LOCKED} state_t;

  state_t                      state, state_next;
  logic [NB_AM-1:0]            am;
  logic [7:0]                  rx_bip;
  logic                        hdr_ok;
  logic [NB_LANE_ID:0]         n_act;
  logic [NB_VAL_AM-1:0]        vthr;
  logic [NB_INV_AM-1:0]        ithr;
  logic [N_ALIGNER-1:0]        hit;
  logic                        any_hit;
  logic [NB_LANE_ID-1:0]       hit_id;
  logic                        pin_hit;
  logic                        am_slot;
  logic [NB_AM_PERIOD-1:0]     pcnt, pcnt_next;
  logic [NB_VAL_AM-1:0]        good, good_next;
  logic [NB_VAL_AM:0]          good_inc;
  logic [NB_INV_AM-1:0]        bad, bad_next;
  logic [NB_INV_AM:0]          bad_inc;
  logic [NB_LANE_ID-1:0]       lane_next;
  logic                        resync_next;
  logic                        err_upd;
  logic                        sub;
  logic                        sol;
  logic                        restart;
  logic [3:0]                  nerr;
  logic [NB_ERROR_COUNTER:0]   err_sum;
  logic [NB_ERROR_COUNTER-1:0] err_sat;

  assign am      = {rx.data[63:40], rx.data[31:8]};
  assign rx_bip  = rx.data[39:32];
  assign hdr_ok  = rx.data[65:64] == 2'b10;
  assign n_act   = (i_rf_n_active == '0) ?
                   (NB_LANE_ID+1)'(1) : i_rf_n_active;
  assign vthr    = (i_rf_valid_am_thr == '0) ?
                   NB_VAL_AM'(1) : i_rf_valid_am_thr;
  assign ithr    = (i_rf_invalid_am_thr == '0) ?
                   NB_INV_AM'(1) : i_rf_invalid_am_thr;
  assign am_slot = rx.valid && (pcnt == i_rf_am_period - 1'b1);

  always_comb begin
    hit = '0;
    for (int k = 0; k < N_ALIGNER; k++)
      hit[k] = hdr_ok && (k < int'(n_act)) &&
               ((am & i_rf_compare_mask) ==
                (AM_TABLE[k*NB_AM +: NB_AM] & i_rf_compare_mask));
  end

  // Scan downwards so the lowest matching candidate wins.
  always_comb begin
    hit_id = '0;
    for (int k = N_ALIGNER-1; k >= 0; k--)
      if (hit[k]) hit_id = NB_LANE_ID'(k);
  end

  assign any_hit  = |hit;
  assign pin_hit  = any_hit && (hit_id == o_lane_id);
  assign good_inc = {1'b0, good} + 1'b1;
  assign bad_inc  = {1'b0, bad} + 1'b1;
  assign nerr     = 4'($countones(rx_bip ^ i_calculated_bip));
  assign err_sum  = {1'b0, o_error_counter} + (NB_ERROR_COUNTER+1)'(nerr);
  assign err_sat  = err_sum[NB_ERROR_COUNTER] ?
                    '1 : err_sum[NB_ERROR_COUNTER-1:0];

  always_comb begin
    state_next  = state;
    pcnt_next   = pcnt;
    good_next   = good;
    bad_next    = bad;
    lane_next   = o_lane_id;
    resync_next = 1'b0;
    err_upd     = 1'b0;
    sub         = 1'b0;
    sol         = 1'b0;
    restart     = 1'b0;
    if (!i_rf_enable) begin
      state_next = SEARCH;
      pcnt_next  = '0;
      good_next  = '0;
      bad_next   = '0;
    end else if (!i_block_lock) begin
      state_next  = SEARCH;
      pcnt_next   = '0;
      good_next   = '0;
      bad_next    = '0;
      resync_next = state == LOCKED;
    end else if (rx.valid) begin
      pcnt_next = am_slot ? '0 : pcnt + 1'b1;
      unique case (state)
        SEARCH: begin
          if (any_hit) begin
            lane_next  = hit_id;
            pcnt_next  = '0;
            good_next  = NB_VAL_AM'(1);
            bad_next   = '0;
            sub        = 1'b1;
            restart    = 1'b1;
            state_next = (vthr == NB_VAL_AM'(1)) ? LOCKED : CONFIRM;
          end
        end
        CONFIRM: begin
          sub = any_hit;
          if (am_slot) begin
            restart = 1'b1;
            if (pin_hit) begin
              sol       = 1'b1;
              good_next = good_inc[NB_VAL_AM-1:0];
              if (good_inc >= {1'b0, vthr}) state_next = LOCKED;
            end else begin
              good_next  = '0;
              state_next = SEARCH;
            end
          end
        end
        LOCKED: begin
          if (am_slot) begin
            sub     = 1'b1;
            restart = 1'b1;
            if (pin_hit) begin
              sol      = 1'b1;
              err_upd  = 1'b1;
              bad_next = '0;
            end else if (bad_inc >= {1'b0, ithr}) begin
              state_next  = SEARCH;
              resync_next = 1'b1;
              bad_next    = '0;
              good_next   = '0;
            end else begin
              bad_next = bad_inc[NB_INV_AM-1:0];
            end
          end
        end
        default: state_next = SEARCH;
      endcase
    end
  end

  assign o_am_lock     = state == LOCKED;
  assign o_bip_restart = i_reset && restart;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state            <= SEARCH;
      pcnt             <= '0;
      good             <= '0;
      bad              <= '0;
      o_lane_id        <= '0;
      o_resync         <= 1'b0;
      o_error_counter  <= '0;
      o_resync_counter <= '0;
      o_start_of_lane  <= 1'b0;
      tx.valid         <= 1'b0;
      tx.data          <= '0;
    end else begin
      state           <= state_next;
      pcnt            <= pcnt_next;
      good            <= good_next;
      bad             <= bad_next;
      o_lane_id       <= lane_next;
      o_resync        <= resync_next;
      o_start_of_lane <= sol;
      tx.valid        <= rx.valid && i_rf_enable;
      tx.data         <= !i_rf_enable ? '0 : sub ? AM_IDLE : rx.data;
      if (resync_next)
        o_error_counter <= '0;
      else if (err_upd)
        o_error_counter <= err_sat;
      if (resync_next && (o_resync_counter != '1))
        o_resync_counter <= o_resync_counter + 1'b1;
    end
  end

endmodule

// File: tb/tb_am_lock_multimode.sv
// Directed bench for am_lock_multimode: lock, unlock, lane pinning,
// BIP counting, block-lock loss, async reset and degenerate settings.
module tb_am_lock_multimode;

  function automatic logic [47:0] am_of(input int k);
    logic [7:0] b;
    b = 8'(k);
    return {24'hC16821 ^ {b, b, b}, 24'h3E97DE + {16'h0, b}};
  endfunction

  function automatic logic [959:0] mk_table();
    logic [959:0] t;
    t = '0;
    for (int k = 0; k < 20; k++) t[k*48 +: 48] = am_of(k);
    return t;
  endfunction

  localparam logic [959:0] TB_TABLE = mk_table();
  localparam logic [65:0]  IDLE = {2'b10, 8'h1E, 56'h0};
  localparam logic [65:0]  CORR = 66'h1 << 50;

  logic        i_clock = 1'b0;
  logic        i_reset;
  logic        i_rf_enable;
  logic        i_block_lock;
  logic [7:0]  i_calculated_bip;
  logic [47:0] i_rf_compare_mask;
  logic [5:0]  i_rf_n_active;
  logic [4:0]  i_rf_valid_am_thr;
  logic [2:0]  i_rf_invalid_am_thr;
  logic [15:0] i_rf_am_period;
  logic        o_start_of_lane;
  logic [4:0]  o_lane_id;
  logic        o_am_lock;
  logic        o_resync;
  logic        o_bip_restart;
  logic [3:0]  o_error_counter;
  logic [7:0]  o_resync_counter;

  am_lock_multimode_if #(.NB_CODED_BLOCK(66)) rx ();
  am_lock_multimode_if #(.NB_CODED_BLOCK(66)) tx ();

  am_lock_multimode #(
    .AM_TABLE(TB_TABLE),
    .NB_ERROR_COUNTER(4)
  ) dut (
    .i_clock(i_clock),
    .i_reset(i_reset),
    .i_rf_enable(i_rf_enable),
    .i_block_lock(i_block_lock),
    .i_calculated_bip(i_calculated_bip),
    .i_rf_compare_mask(i_rf_compare_mask),
    .i_rf_n_active(i_rf_n_active),
    .i_rf_valid_am_thr(i_rf_valid_am_thr),
    .i_rf_invalid_am_thr(i_rf_invalid_am_thr),
    .i_rf_am_period(i_rf_am_period),
    .rx(rx),
    .tx(tx),
    .o_start_of_lane(o_start_of_lane),
    .o_lane_id(o_lane_id),
    .o_am_lock(o_am_lock),
    .o_resync(o_resync),
    .o_bip_restart(o_bip_restart),
    .o_error_counter(o_error_counter),
    .o_resync_counter(o_resync_counter)
  );

  always #5 i_clock = ~i_clock;

  int          n_chk = 0;
  int          n_fail = 0;
  int          sol_n;
  int          pass_bad;
  logic [31:0] dcnt = 32'h1000;
  logic        restart_s;
  logic [65:0] am_data;
  logic        am_sol;
  logic        am_restart;
  logic        am_resync;
  logic        am_lock;

  task automatic chk(input string tag,
                     input logic [65:0] got,
                     input logic [65:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [65:0] am_blk(input int k, input logic [7:0] bip);
    logic [47:0] a;
    a = am_of(k);
    return {2'b10, a[47:24], bip, a[23:0], ~bip};
  endfunction

  task automatic drive(input logic [65:0] d, input logic [7:0] cb,
                       input logic v);
    @(negedge i_clock);
    rx.valid = v;
    rx.data = d;
    i_calculated_bip = cb;
    #1 restart_s = o_bip_restart;
    @(posedge i_clock);
    #1;
  endtask

  task automatic frame(input int k, input logic [7:0] rbip,
                       input logic [7:0] cbip, input logic [65:0] flip);
    logic [65:0] b;
    b = am_blk(k, rbip) ^ flip;
    drive(b, cbip, 1'b1);
    am_data = tx.data;
    am_sol = o_start_of_lane;
    am_restart = restart_s;
    am_resync = o_resync;
    am_lock = o_am_lock;
    sol_n = 0;
    pass_bad = 0;
    for (int i = 1; i < 16; i++) begin
      dcnt = dcnt + 1;
      b = {2'b01, dcnt, ~dcnt};
      drive(b, 8'h00, 1'b1);
      if (o_start_of_lane) sol_n++;
      if (tx.data !== b || tx.valid !== 1'b1) pass_bad++;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    i_reset = 1'b0;
    i_rf_enable = 1'b1;
    i_block_lock = 1'b1;
    i_calculated_bip = 8'h00;
    i_rf_compare_mask = '1;
    i_rf_n_active = 6'd20;
    i_rf_valid_am_thr = 5'd3;
    i_rf_invalid_am_thr = 3'd4;
    i_rf_am_period = 16'd16;
    rx.valid = 1'b0;
    rx.data = '0;
    repeat (3) @(posedge i_clock);
    #1;
    chk("rst_lock", 66'(o_am_lock), 66'(0));
    chk("rst_valid", 66'(tx.valid), 66'(0));
    chk("rst_data", tx.data, 66'(0));
    chk("rst_err", 66'(o_error_counter), 66'(0));
    chk("rst_rcnt", 66'(o_resync_counter), 66'(0));
    chk("rst_lane", 66'(o_lane_id), 66'(0));
    @(negedge i_clock);
    i_reset = 1'b1;

    // T1: lock on lane 7
    frame(7, 8'hA5, 8'hA5, '0);
    chk("t1_restart", 66'(am_restart), 66'(1));
    chk("t1_sub_search", am_data, IDLE);
    chk("t1_lock1", 66'(am_lock), 66'(0));
    frame(7, 8'hA5, 8'hA5, '0);
    chk("t1_sol2", 66'(am_sol), 66'(1));
    chk("t1_lock2", 66'(am_lock), 66'(0));
    frame(7, 8'hA5, 8'hA5, '0);
    chk("t1_lock3", 66'(am_lock), 66'(1));
    chk("t1_lane", 66'(o_lane_id), 66'(7));
    frame(7, 8'hA5, 8'hA5, '0);
    chk("t1_sol4", 66'(am_sol), 66'(1));
    chk("t1_idle4", am_data, IDLE);
    chk("t1_sol_data", 66'(sol_n), 66'(0));
    chk("t1_pass", 66'(pass_bad), 66'(0));

    // T2: 3 misses then good, then 4 misses
    for (int i = 0; i < 3; i++) frame(7, 8'hA5, 8'hA5, CORR);
    chk("t2_idle_miss", am_data, IDLE);
    chk("t2_sol_miss", 66'(am_sol), 66'(0));
    chk("t2_lock_3bad", 66'(am_lock), 66'(1));
    frame(7, 8'hA5, 8'hA5, '0);
    chk("t2_err", 66'(o_error_counter), 66'(0));
    for (int i = 0; i < 3; i++) frame(7, 8'hA5, 8'hA5, CORR);
    chk("t2_lock_3bad_b", 66'(am_lock), 66'(1));
    frame(7, 8'hA5, 8'hA5, CORR);
    chk("t2_resync", 66'(am_resync), 66'(1));
    chk("t2_unlock", 66'(am_lock), 66'(0));
    chk("t2_idle4", am_data, IDLE);
    chk("t2_rcnt", 66'(o_resync_counter), 66'(1));
    chk("t2_pulse_end", 66'(o_resync), 66'(0));

    // T3: relock on lane 2, lane 5 AM is a miss
    for (int i = 0; i < 3; i++) frame(2, 8'h3C, 8'h3C, '0);
    chk("t3_lock", 66'(am_lock), 66'(1));
    chk("t3_lane2", 66'(o_lane_id), 66'(2));
    frame(5, 8'h3C, 8'h3C, '0);
    chk("t3_other_lock", 66'(am_lock), 66'(1));
    chk("t3_other_sol", 66'(am_sol), 66'(0));
    chk("t3_other_lane", 66'(o_lane_id), 66'(2));
    frame(2, 8'h3C, 8'h3C, '0);
    chk("t3_back_sol", 66'(am_sol), 66'(1));

    // T4: BIP errors, 4 per slot, 4-bit counter saturates at 15
    frame(2, 8'hFF, 8'h0F, '0);
    frame(2, 8'hFF, 8'h0F, '0);
    chk("t4_err8", 66'(o_error_counter), 66'(8));
    frame(2, 8'hFF, 8'h0F, '0);
    chk("t4_err12", 66'(o_error_counter), 66'(12));
    frame(2, 8'hFF, 8'h0F, '0);
    chk("t4_err_sat", 66'(o_error_counter), 66'(15));

    // T5: block lock loss while locked
    i_block_lock = 1'b0;
    drive('0, 8'h00, 1'b0);
    chk("t5_resync", 66'(o_resync), 66'(1));
    chk("t5_unlock", 66'(o_am_lock), 66'(0));
    chk("t5_rcnt", 66'(o_resync_counter), 66'(2));
    chk("t5_err_clr", 66'(o_error_counter), 66'(0));
    i_block_lock = 1'b1;
    drive('0, 8'h00, 1'b0);
    chk("t5_pulse_end", 66'(o_resync), 66'(0));

    // n_active=4: lane 9 ignored
    i_rf_n_active = 6'd4;
    frame(9, 8'h11, 8'h11, '0);
    frame(9, 8'h11, 8'h11, '0);
    chk("t3_nact_lock", 66'(am_lock), 66'(0));
    chk("t3_nact_pass", am_data, am_blk(9, 8'h11));
    chk("t3_nact_restart", 66'(am_restart), 66'(0));

    // reset in CONFIRM, then relock from scratch
    frame(2, 8'h3C, 8'h3C, '0);
    frame(2, 8'h3C, 8'h3C, '0);
    @(negedge i_clock);
    i_reset = 1'b0;
    #1;
    chk("t5_arst_valid", 66'(tx.valid), 66'(0));
    chk("t5_arst_data", tx.data, 66'(0));
    chk("t5_arst_lane", 66'(o_lane_id), 66'(0));
    chk("t5_arst_rcnt", 66'(o_resync_counter), 66'(0));
    chk("t5_arst_restart", 66'(o_bip_restart), 66'(0));
    @(negedge i_clock);
    i_reset = 1'b1;
    frame(2, 8'h3C, 8'h3C, '0);
    frame(2, 8'h3C, 8'h3C, '0);
    chk("t5_relock2", 66'(am_lock), 66'(0));
    frame(2, 8'h3C, 8'h3C, '0);
    chk("t5_relock3", 66'(am_lock), 66'(1));

    // T6: zero threshold, zero mask
    i_block_lock = 1'b0;
    drive('0, 8'h00, 1'b0);
    chk("t6_rcnt", 66'(o_resync_counter), 66'(1));
    i_block_lock = 1'b1;
    i_rf_compare_mask = '0;
    i_rf_valid_am_thr = '0;
    drive({2'b10, 64'h0123456789ABCDEF}, 8'h00, 1'b1);
    chk("t6_restart", 66'(restart_s), 66'(1));
    chk("t6_lock", 66'(o_am_lock), 66'(1));
    chk("t6_lane0", 66'(o_lane_id), 66'(0));
    chk("t6_idle", tx.data, IDLE);

    // disable: no output, no resync
    i_rf_enable = 1'b0;
    drive({2'b01, 64'h55AA55AA55AA55AA}, 8'h00, 1'b1);
    chk("en_valid", 66'(tx.valid), 66'(0));
    chk("en_data", tx.data, 66'(0));
    chk("en_lock", 66'(o_am_lock), 66'(0));
    chk("en_resync", 66'(o_resync), 66'(0));
    chk("en_rcnt", 66'(o_resync_counter), 66'(1));

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
